// File: rtl/alu_sequencer.sv
// Issue-side controller for the 8-bit ALU datapath: owns the register file,
// stages operands/controls to the ALU and writes busC back to rd.
module alu_sequencer #(
  parameter int MAX_WIDTH = 8,
  parameter int NREGS     = 8,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic                 op_ldi,
  input  logic [2:0]           op_selop,
  input  logic [1:0]           op_shamt,
  input  logic                 op_setf,
  input  logic [AW-1:0]        rd,
  input  logic [AW-1:0]        rs,
  input  logic [AW-1:0]        rt,
  input  logic [MAX_WIDTH-1:0] imm,
  output logic [MAX_WIDTH-1:0] busA,
  output logic [MAX_WIDTH-1:0] busB,
  output logic [2:0]           selop,
  output logic [1:0]           shamt,
  output logic                 enaf,
  input  logic [MAX_WIDTH-1:0] busC,
  input  logic                 C,
  input  logic                 N,
  input  logic                 P,
  input  logic                 Z,
  output logic [3:0]           flags,
  output logic [MAX_WIDTH-1:0] result,
  output logic                 done
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, DONE} state_e;

  state_e               state_q, state_d;
  logic                 ldi_q, ldi_d, setf_q, setf_d;
  logic [2:0]           opsel_q, opsel_d;
  logic [1:0]           opsh_q, opsh_d;
  logic [AW-1:0]        rd_q, rd_d, rs_q, rs_d, rt_q, rt_d;
  logic [MAX_WIDTH-1:0] imm_q, imm_d;
  logic [MAX_WIDTH-1:0] regs_q [NREGS];
  logic [MAX_WIDTH-1:0] regs_d [NREGS];
  logic [MAX_WIDTH-1:0] busa_q, busa_d, busb_q, busb_d;
  logic [2:0]           selop_q, selop_d;
  logic [1:0]           shamt_q, shamt_d;
  logic [MAX_WIDTH-1:0] result_q, result_d;
  logic [3:0]           flags_q, flags_d;
  logic [MAX_WIDTH-1:0] rs_val, rt_val;

  // r0 is hard-wired to zero on the read side; writes to it are dropped below.
  assign rs_val = (rs_q == '0) ? '0 : regs_q[rs_q];
  assign rt_val = (rt_q == '0) ? '0 : regs_q[rt_q];

  always_comb begin
    state_d  = state_q;
    ldi_d    = ldi_q;
    setf_d   = setf_q;
    opsel_d  = opsel_q;
    opsh_d   = opsh_q;
    rd_d     = rd_q;
    rs_d     = rs_q;
    rt_d     = rt_q;
    imm_d    = imm_q;
    regs_d   = regs_q;
    busa_d   = busa_q;
    busb_d   = busb_q;
    selop_d  = selop_q;
    shamt_d  = shamt_q;
    result_d = result_q;
    flags_d  = flags_q;
    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          ldi_d   = op_ldi;
          setf_d  = op_setf;
          opsel_d = op_selop;
          opsh_d  = op_shamt;
          rd_d    = rd;
          rs_d    = rs;
          rt_d    = rt;
          imm_d   = imm;
          state_d = FETCH;
        end
      end
      FETCH: begin
        selop_d = opsel_q;
        shamt_d = opsh_q;
        if (ldi_q) begin
          if (rd_q != '0) regs_d[rd_q] = imm_q;
          result_d = imm_q;
          state_d  = DONE;
        end else begin
          busa_d  = rs_val;
          busb_d  = rt_val;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (rd_q != '0) regs_d[rd_q] = busC;
        result_d = busC;
        state_d  = DONE;
      end
      DONE: begin
        // The ALU flag register settled on the EXEC closing edge.
        flags_d = {C, N, P, Z};
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ldi_q    <= 1'b0;
      setf_q   <= 1'b0;
      opsel_q  <= '0;
      opsh_q   <= '0;
      rd_q     <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      imm_q    <= '0;
      regs_q   <= '{default: '0};
      busa_q   <= '0;
      busb_q   <= '0;
      selop_q  <= '0;
      shamt_q  <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      ldi_q    <= ldi_d;
      setf_q   <= setf_d;
      opsel_q  <= opsel_d;
      opsh_q   <= opsh_d;
      rd_q     <= rd_d;
      rs_q     <= rs_d;
      rt_q     <= rt_d;
      imm_q    <= imm_d;
      regs_q   <= regs_d;
      busa_q   <= busa_d;
      busb_q   <= busb_d;
      selop_q  <= selop_d;
      shamt_q  <= shamt_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign instr_ready = (state_q == IDLE) && !rst;
  assign done        = (state_q == DONE);
  assign enaf        = (state_q == EXEC) && setf_q;
  assign busA        = busa_q;
  assign busB        = busb_q;
  assign selop       = selop_q;
  assign shamt       = shamt_q;
  assign result      = result_q;
  assign flags       = flags_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a small add/pass ALU and flag register.
module tb_alu_sequencer;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         instr_valid, instr_ready, op_ldi, op_setf, enaf, done;
  logic [2:0]   op_selop, selop, rd, rs, rt;
  logic [1:0]   op_shamt, shamt;
  logic [W-1:0] imm, busA, busB, busC, result;
  logic         C, N, P, Z;
  logic [3:0]   flags;
  logic [W+3:0] alu_o;

  int nvec = 0;
  int nbad = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.MAX_WIDTH(W), .NREGS(8)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .op_ldi(op_ldi), .op_selop(op_selop), .op_shamt(op_shamt), .op_setf(op_setf),
    .rd(rd), .rs(rs), .rt(rt), .imm(imm), .busA(busA), .busB(busB),
    .selop(selop), .shamt(shamt), .enaf(enaf), .busC(busC),
    .C(C), .N(N), .P(P), .Z(Z), .flags(flags), .result(result), .done(done)
  );

  // Returns {C,N,P,Z,result}; P is set for an even number of ones.
  function automatic logic [W+3:0] alu(input logic [2:0] sel, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = (sel == 3'd0) ? ({1'b0, a} + {1'b0, b}) : {1'b0, a};
    return {s[W], s[W-1], ~^s[W-1:0], s[W-1:0] == '0, s[W-1:0]};
  endfunction

  assign alu_o = alu(selop, busA, busB);
  assign busC  = alu_o[W-1:0];

  always @(posedge clk or posedge rst)
    if (rst) {C, N, P, Z} <= 4'b0;
    else if (enaf) {C, N, P, Z} <= alu_o[W+3:W];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {logic [W-1:0] res; logic [3:0] fl;} exp_t;
  exp_t         sbq[$];
  logic [W-1:0] mreg [8];
  logic [3:0]   mfl, fl_exp;
  logic         fl_pend;
  logic [W-1:0] exp_a, exp_b;

  // Reference model advances on accept; the DUT's outputs are popped at done.
  always @(negedge clk) begin
    exp_t         e;
    logic [W-1:0] a, b;
    logic [W+3:0] o;
    if (rst) begin
      sbq.delete();
      for (int i = 0; i < 8; i++) mreg[i] = '0;
      mfl     = 4'b0;
      fl_pend = 1'b0;
    end else begin
      if (fl_pend) begin
        chk("flags", {28'b0, flags}, {28'b0, fl_exp});
        fl_pend = 1'b0;
      end
      if (done) begin
        if (sbq.size() == 0) chk("sb_empty", 32'd1, 32'd0);
        else begin
          e = sbq.pop_front();
          chk("result", {24'b0, result}, {24'b0, e.res});
          fl_exp  = e.fl;
          fl_pend = 1'b1;
        end
      end
      if (instr_valid && instr_ready) begin
        a = (rs == 3'd0) ? '0 : mreg[rs];
        b = (rt == 3'd0) ? '0 : mreg[rt];
        exp_a = a;
        exp_b = b;
        if (op_ldi) e.res = imm;
        else begin
          o = alu(op_selop, a, b);
          e.res = o[W-1:0];
          if (op_setf) mfl = o[W+3:W];
        end
        if (rd != 3'd0) mreg[rd] = e.res;
        e.fl = mfl;
        sbq.push_back(e);
      end
    end
  end

  task automatic issue(input logic ldi, input logic [2:0] sel, input logic setf,
                       input logic [2:0] d, input logic [2:0] s, input logic [2:0] t,
                       input logic [W-1:0] im);
    logic [W-1:0] a0, b0;
    int n;
    @(posedge clk); #1;
    op_ldi = ldi; op_selop = sel; op_shamt = 2'd1; op_setf = setf;
    rd = d; rs = s; rt = t; imm = im; instr_valid = 1'b1;
    n = 0;
    while (!instr_ready && n < 20) begin @(posedge clk); #1; n++; end
    if (!instr_ready) chk("ready_timeout", 32'd0, 32'd1);
    a0 = busA; b0 = busB;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    op_ldi = $urandom_range(0, 1); op_selop = 3'($urandom); op_setf = $urandom_range(0, 1);
    rd = 3'($urandom); rs = 3'($urandom); rt = 3'($urandom); imm = 8'($urandom);
    n = 1;
    while (!done && n < 10) begin
      chk("rdy_busy", {31'b0, instr_ready}, 32'd0);
      chk("enaf", {31'b0, enaf}, {31'b0, (!ldi && setf && n == 2)});
      if (n == 2 && !ldi) begin
        chk("busA", {24'b0, busA}, {24'b0, exp_a});
        chk("busB", {24'b0, busB}, {24'b0, exp_b});
        chk("selop", {29'b0, selop}, {29'b0, sel});
      end
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, ldi ? 32'd2 : 32'd3);
    if (ldi) begin
      chk("ldi_busA", {24'b0, busA}, {24'b0, a0});
      chk("ldi_busB", {24'b0, busB}, {24'b0, b0});
    end
    @(posedge clk); #1;
    chk("enaf_idle", {31'b0, enaf}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int acc;
    rst = 1'b1; instr_valid = 1'b0; op_ldi = 1'b0; op_selop = '0; op_shamt = '0;
    op_setf = 1'b0; rd = '0; rs = '0; rt = '0; imm = '0;
    #1 chk("rst_ready", {31'b0, instr_ready}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busA", {24'b0, busA}, 32'd0);
    chk("rst_busB", {24'b0, busB}, 32'd0);
    chk("rst_result", {24'b0, result}, 32'd0);
    chk("rst_flags", {28'b0, flags}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_enaf", {31'b0, enaf}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_idle", {31'b0, instr_ready}, 32'd1);

    issue(1'b1, 3'd0, 1'b0, 3'd1, 3'd0, 3'd0, 8'h05);
    chk("ldi_r1", {24'b0, result}, 32'h05);
    issue(1'b1, 3'd0, 1'b0, 3'd2, 3'd0, 3'd0, 8'h0A);
    chk("ldi_r2", {24'b0, result}, 32'h0A);
    chk("ldi_busA0", {24'b0, busA}, 32'd0);
    issue(1'b0, 3'd0, 1'b1, 3'd3, 3'd1, 3'd2, 8'h00);
    chk("add_r3", {24'b0, result}, 32'h0F);

    issue(1'b1, 3'd0, 1'b0, 3'd1, 3'd0, 3'd0, 8'hFF);
    issue(1'b1, 3'd0, 1'b0, 3'd2, 3'd0, 3'd0, 8'h01);
    issue(1'b0, 3'd0, 1'b1, 3'd1, 3'd1, 3'd2, 8'h00);
    chk("wrap_res", {24'b0, result}, 32'h00);
    chk("flags_cz", {28'b0, flags}, 32'b1011);
    issue(1'b1, 3'd0, 1'b0, 3'd1, 3'd0, 3'd0, 8'h10);
    issue(1'b0, 3'd0, 1'b0, 3'd1, 3'd1, 3'd2, 8'h00);
    chk("nosetf_res", {24'b0, result}, 32'h11);
    chk("nosetf_flags", {28'b0, flags}, 32'b1011);

    issue(1'b1, 3'd0, 1'b0, 3'd0, 3'd0, 3'd0, 8'h33);
    chk("ldi_r0", {24'b0, result}, 32'h33);
    issue(1'b0, 3'd0, 1'b0, 3'd4, 3'd0, 3'd0, 8'h00);
    chk("r0_add", {24'b0, result}, 32'h00);
    issue(1'b0, 3'd1, 1'b0, 3'd5, 3'd3, 3'd0, 8'h00);
    chk("pass_r3", {24'b0, result}, 32'h0F);

    // Valid held high with fields changing every cycle: ALU ops only.
    @(posedge clk); #1;
    acc = 0;
    instr_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      op_ldi = 1'b0; op_selop = 3'($urandom_range(0, 1)); op_setf = $urandom_range(0, 1);
      rd = 3'($urandom); rs = 3'($urandom); rt = 3'($urandom); imm = 8'($urandom);
      @(negedge clk);
      chk("rdy_pattern", {31'b0, instr_ready}, {31'b0, (i % 4 == 0)});
      if (instr_ready) acc++;
      @(posedge clk); #1;
    end
    instr_valid = 1'b0;
    chk("accepts", acc, 32'd4);
    repeat (6) @(posedge clk);
    #1;
    chk("drained", 32'(sbq.size()), 32'd0);

    // Reset while in EXEC aborts the op.
    op_ldi = 1'b0; op_selop = 3'd0; op_setf = 1'b1; rd = 3'd6; rs = 3'd1; rt = 3'd2;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    chk("exec_enaf", {31'b0, enaf}, 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_enaf", {31'b0, enaf}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    chk("abort_ready", {31'b0, instr_ready}, 32'd0);
    @(posedge clk); #1;
    chk("abort_done2", {31'b0, done}, 32'd0);
    chk("abort_result", {24'b0, result}, 32'd0);
    rst = 1'b0;
    #1 chk("ready_back", {31'b0, instr_ready}, 32'd1);
    issue(1'b0, 3'd1, 1'b0, 3'd7, 3'd1, 3'd0, 8'h00);
    chk("r1_cleared", {24'b0, result}, 32'h00);
    issue(1'b0, 3'd1, 1'b0, 3'd7, 3'd6, 3'd0, 8'h00);
    chk("r6_nowrite", {24'b0, result}, 32'h00);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Issue-side controller for the 8-bit ALU datapath.
- Accepts one instruction at a time over a valid/ready handshake. Holds an internal register file and drives ALU operands and controls (busA, busB, selop, shamt, enaf).
- Captures busC back into the destination register and pulses done.
- Sits between the instruction source and the ALU. The ALU's combinational result path and flag register are external.

Parameters:
- MAX_WIDTH, 8, data width of registers, busA/busB/busC, imm.
- NREGS, 8, number of registers; address width is clog2(NREGS) = 3 at default.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- instr_valid  input  1  instruction fields valid.
- instr_ready  output  1  sequencer can accept; equals (state==IDLE) and not rst.
- op_ldi  input  1  1 = load immediate (bypasses ALU), 0 = ALU op.
- op_selop  input  3  ALU operation select.
- op_shamt  input  2  ALU shift amount.
- op_setf  input  1  update ALU flags for this op.
- rd  input  3  destination register.
- rs  input  3  source A register.
- rt  input  3  source B register.
- imm  input  MAX_WIDTH  immediate for op_ldi.
- busA  output  MAX_WIDTH  registered operand A to ALU.
- busB  output  MAX_WIDTH  registered operand B to ALU.
- selop  output  3  registered, to ALU.
- shamt  output  2  registered, to ALU.
- enaf  output  1  flag-register enable to ALU.
- busC  input  MAX_WIDTH  ALU result.
- C, N, P, Z  input  1 each  ALU flag register outputs.
- flags  output  4  {C,N,P,Z} snapshot taken at DONE.
- result  output  MAX_WIDTH  value written by the last completed instruction.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (async, immediate):
  - state=IDLE.
  - All registers, busA, busB, selop, shamt, result and flags go to 0; enaf=0, done=0.
  - instr_ready=0 while rst is high.
- States: IDLE, FETCH, EXEC, DONE.
- IDLE:
  - instr_ready=1.
  - On instr_valid&instr_ready, latch all op fields and go to FETCH.
  - Otherwise stay in IDLE; busA/busB/selop/shamt hold their previous values.
- FETCH:
  - Load busA<=reg[rs], busB<=reg[rt], selop<=op_selop, shamt<=op_shamt.
  - If ldi: write reg[rd]<=imm, result<=imm, go to DONE. busA/busB are not updated for ldi.
  - Else go to EXEC.
- EXEC:
  - enaf = latched op_setf; enaf is low in every other state.
  - At the closing edge: reg[rd]<=busC, result<=busC. The ALU flag register updates on this same edge.
  - Go to DONE.
- DONE:
  - done=1 for exactly this cycle.
  - flags<={C,N,P,Z} sampled at the closing edge, so flags is visible from the next cycle.
  - Go to IDLE.
- Latency:
  - Accept at edge k.
  - ALU op: done high in cycle k+3; next accept possible at edge k+4.
  - ldi: done in cycle k+2.
- Register 0:
  - Reads of reg 0 return 0.
  - Writes to rd=0 are discarded, but result still takes the written value and done still pulses.
- Operand overlap:
  - rs==rt, rd==rs or rd==rt are legal.
  - Operands are sampled in FETCH before the write in EXEC.
  - Back-to-back dependent instructions see the new value, since execution is strictly serial.
- Input-change rules:
  - instr_valid is ignored outside IDLE.
  - Instruction fields may change freely after acceptance.
- Reset mid-operation: abort immediately. No register write, no done pulse, enaf drops to 0.
- Arithmetic is owned by the ALU; the sequencer applies no width conversion. Registers hold exactly MAX_WIDTH bits.

Test Plan:
- Bench ALU model: busC=busA+busB when selop=0, busC=busA when selop=1; flag register standard.
- Reset, then ldi r1=0x05 and ldi r2=0x0A → done at accept+2 each; result=0x05 then 0x0A; busA/busB stay 0.
- ALU op selop=0, rd=3, rs=1, rt=2, setf=1 → FETCH busA=0x05, busB=0x0A; enaf high only in EXEC; r3=0x0F; result=0x0F; done at accept+3.
- ldi r1=0xFF, ldi r2=0x01, add r1=r1+r2 with setf=1 → r1=0x00; flags show C=1, Z=1 after DONE. Repeat with setf=0 → flags unchanged.
- Write to r0 (ldi r0=0x33), then ALU op rs=0, rt=0, rd=4 → done pulses with result=0x33 on the ldi; r4=0x00.
- Hold instr_valid high continuously with changing fields → exactly one accept per 4 cycles; instr_ready low in FETCH/EXEC/DONE; no field changes leak into an in-flight op.
- Assert rst during EXEC → no write to rd, done stays 0, enaf=0 immediately; registers read 0 afterwards; instr_ready returns after rst deasserts.
